// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY0,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } seq_state_e;

endpackage

// File: rtl/aes_round_ctr.sv
// Round counter for the AES sequencer: loads 1, steps up to NR and flags the final round.
module aes_round_ctr #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       load_one,
    input  logic       step,
    output logic [3:0] round,
    output logic       last
);

    assign last = (round == 4'(NR));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round <= 4'd0;
        end else if (clear) begin
            round <= 4'd0;
        end else if (load_one) begin
            round <= 4'd1;
        end else if (step && !last) begin
            // Saturates at NR so the counter can never wrap.
            round <= round + 4'd1;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller driving an external single-round datapath.
// Optional dp_done watchdog with sticky err output: define AES_SEQ_TIMEOUT_EN.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR             = AES128_NR,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_block_t in_block,
    output logic [3:0] rk_idx,
    input  aes_block_t rk_data,
    output logic       dp_start,
    output aes_block_t dp_state,
    output aes_block_t dp_key,
    output logic       dp_skip_mix,
    input  logic       dp_done,
    input  aes_block_t dp_result,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_block_t out_block,
`ifdef AES_SEQ_TIMEOUT_EN
    output logic       err,
`endif
    output logic       busy
);

    seq_state_e state;
    aes_block_t blk_q;
    logic [3:0] round;
    logic       last;
    logic       accept;
    logic       round_done;

    assign accept     = (state == ST_IDLE) && in_valid;
    assign round_done = (state == ST_WAIT) && dp_done;

    aes_round_ctr #(.NR(NR)) u_round_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (accept),
        .load_one (state == ST_KEY0),
        .step     (round_done),
        .round    (round),
        .last     (last)
    );

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
`endif

    // NOTE: every register here, including the wide data ones, is assigned with <= and
    // has an explicit reset value so a mid-block reset leaves nothing stale on the ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            dp_start    <= 1'b0;
            dp_skip_mix <= 1'b0;
            busy        <= 1'b0;
            rk_idx      <= 4'd0;
            dp_state    <= '0;
            dp_key      <= '0;
            out_block   <= '0;
            blk_q       <= '0;
`ifdef AES_SEQ_TIMEOUT_EN
            err         <= 1'b0;
            wd          <= '0;
`endif
        end else begin
            dp_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rk_idx <= 4'd0;
                    if (accept) begin
                        blk_q    <= in_block ^ rk_data;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_KEY0;
`ifdef AES_SEQ_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                    end
                end
                ST_KEY0: begin
                    rk_idx <= 4'd1;
                    state  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    dp_key      <= rk_data;
                    dp_state    <= blk_q;
                    dp_start    <= 1'b1;
                    dp_skip_mix <= last;
                    state       <= ST_WAIT;
`ifdef AES_SEQ_TIMEOUT_EN
                    wd          <= '0;
`endif
                end
                ST_WAIT: begin
                    if (dp_done) begin
                        blk_q <= dp_result;
                        if (last) begin
                            out_block <= dp_result;
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            rk_idx <= round + 4'd1;
                            state  <= ST_ISSUE;
                        end
                    end
`ifdef AES_SEQ_TIMEOUT_EN
                    else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // Datapath hung: drop the block and flag it until the next accept.
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        rk_idx   <= 4'd0;
                        state    <= ST_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        rk_idx    <= 4'd0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using a FIPS-197 C.1 known-answer round datapath.
// Exercises the AES_SEQ_TIMEOUT_EN watchdog when that macro is defined.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    localparam int NR = 10;
    localparam int TIMEOUT_CYCLES = 15;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    aes_block_t in_block;
    logic [3:0] rk_idx;
    aes_block_t rk_data;
    logic       dp_start;
    aes_block_t dp_state;
    aes_block_t dp_key;
    logic       dp_skip_mix;
    logic       dp_done;
    aes_block_t dp_result;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out_block;
    logic       busy;
`ifdef AES_SEQ_TIMEOUT_EN
    logic       err;
`endif

    aes_round_sequencer #(.NR(NR), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_block    (in_block),
        .rk_idx      (rk_idx),
        .rk_data     (rk_data),
        .dp_start    (dp_start),
        .dp_state    (dp_state),
        .dp_key      (dp_key),
        .dp_skip_mix (dp_skip_mix),
        .dp_done     (dp_done),
        .dp_result   (dp_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_block   (out_block),
`ifdef AES_SEQ_TIMEOUT_EN
        .err         (err),
`endif
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Known-answer vectors (FIPS-197 appendix C.1).
    localparam aes_block_t KEY       = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_block_t PT        = 128'h00112233445566778899aabbccddeeff;
    localparam aes_block_t CT        = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_block_t PT_XOR_K0 = 128'h00102030405060708090a0b0c0d0e0f0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES reference round + key store ----------------
    logic [7:0] sbox [0:255];
    aes_block_t rk [0:10];

    assign rk_data = (rk_idx <= 4'd10) ? rk[rk_idx] : '0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic aes_block_t aes_round(input aes_block_t s, input aes_block_t k, input logic skip);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] c0, c1, c2, c3;
        aes_block_t r;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                b[row + 4*col] = a[row + 4*((col + row) % 4)];
        if (!skip) begin
            for (int col = 0; col < 4; col++) begin
                c0 = b[4*col]; c1 = b[4*col+1]; c2 = b[4*col+2]; c3 = b[4*col+3];
                b[4*col]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                b[4*col+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                b[4*col+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                b[4*col+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i] ^ k[127-8*i -: 8];
        return r;
    endfunction

    initial begin
        logic [7:0]  inv;
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        aes_block_t  key_v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        key_v = KEY;
        for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end

    // ---------------- Datapath model (sole driver of dp_done/dp_result) ----------------
    int         dfix     = 1;   // 0 selects a random delay of 1..6 per round
    logic       withhold = 1'b0;
    int         spur_req = 0;
    int         spur_seen;
    int         dp_cnt;
    int         n_starts;
    aes_block_t pending;
    logic [39:0] rk_seq;
    logic [9:0]  skip_seq;
    aes_block_t  first_state;

    initial begin
        dp_done = 1'b0; dp_result = '0; dp_cnt = 0; n_starts = 0; spur_seen = 0;
        rk_seq = '0; skip_seq = '0; first_state = '0; pending = '0;
        forever begin
            @(negedge clk);
            dp_done = 1'b0;
            if (spur_req != spur_seen) begin
                spur_seen = spur_req;
                dp_done   = 1'b1;
                dp_result = {4{32'hdeadbeef}};
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    dp_done   = 1'b1;
                    dp_result = pending;
                end
            end
            if (dp_start) begin
                n_starts++;
                rk_seq   = {rk_seq[35:0], rk_idx};
                skip_seq = {skip_seq[8:0], dp_skip_mix};
                if (rk_idx == 4'd1) first_state = dp_state;
                if (!withhold) begin
                    dp_cnt  = (dfix > 0) ? dfix : int'($urandom_range(1, 6));
                    pending = aes_round(dp_state, dp_key, dp_skip_mix);
                end
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic send_block(input aes_block_t pt);
        int g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("send_ready_timeout", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_block = pt;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen; lat=1 is the cycle right after accept.
    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            lat++;
            if (out_valid) break;
            if (lat > 2000) begin
                check("out_valid_timeout", 128'(out_valid), 128'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int          lat;
        int          g;
        int          snap;
        logic        stable;
        logic [39:0] exp_rk;
        reset_n = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        exp_rk = '0;
        for (int i = 1; i <= 10; i++) exp_rk = {exp_rk[35:0], 4'(i)};

        repeat (2) @(negedge clk);
        check("reset_ctl", 128'({in_ready, out_valid, dp_start, dp_skip_mix, busy, rk_idx}), 128'h100);
        check("reset_data", dp_state | dp_key | out_block, '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_rk_idx", 128'(rk_idx), 128'd0);

        // Known-answer block, D=1, downstream stalled.
        send_block(PT);
        check("in_ready_drop", 128'({in_ready, busy}), 128'b01);
        wait_out(lat);
        check("latency_d1", 128'(lat), 128'd32);
        check("ciphertext_1", out_block, CT);
        check("first_dp_state", first_state, PT_XOR_K0);
        check("rk_idx_seq", 128'(rk_seq), 128'(exp_rk));
        check("skip_mix_seq", 128'(skip_seq), 128'b0000000001);

        stable = 1'b1;
        snap = n_starts;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_block !== CT || in_ready || n_starts != snap) stable = 1'b0;
        end
        check("out_hold_stable", 128'(stable), 128'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("out_release", 128'({out_valid, in_ready, busy}), 128'b010);

        // Reset during round 5, then a fresh block.
        snap = n_starts;
        send_block(PT);
        g = 0;
        while (n_starts - snap < 5 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("reached_round5", 128'(n_starts - snap), 128'd5);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ctl", 128'({in_ready, out_valid, dp_start, dp_skip_mix, busy, rk_idx}), 128'h100);
        check("async_reset_data", dp_state | dp_key | out_block, '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_idle", 128'({in_ready, busy, out_valid}), 128'b100);

        send_block(PT);
        wait_out(lat);
        check("latency_after_reset", 128'(lat), 128'd32);
        check("ciphertext_after_reset", out_block, CT);
        @(negedge clk);

        // Spurious dp_done while idle must be ignored.
        spur_req++;
        repeat (3) @(negedge clk);
        check("spurious_ignored", 128'({in_ready, busy, out_valid}), 128'b100);

        // Random datapath delay per round.
        dfix = 0;
        send_block(PT);
        wait_out(lat);
        check("ciphertext_var_d", out_block, CT);
        @(negedge clk);
        dfix = 1;

`ifdef AES_SEQ_TIMEOUT_EN
        withhold = 1'b1;
        stable = 1'b0;
        send_block(PT);
        g = 0;
        while (!dp_start && g < 50) begin
            @(negedge clk);
            g++;
        end
        g = 0;
        do begin
            @(negedge clk);
            g++;
            if (out_valid) stable = 1'b1;
        end while (busy && g < 100);
        check("timeout_wait_cycles", 128'(g), 128'(TIMEOUT_CYCLES));
        check("timeout_err_idle", 128'({err, busy, in_ready, stable}), 128'b1010);
        withhold = 1'b0;
        repeat (3) @(negedge clk);
        send_block(PT);
        check("err_cleared", 128'(err), 128'd0);
        wait_out(lat);
        check("ciphertext_after_timeout", out_block, CT);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
